// File: rtl/btn_if.sv
// Pushbutton bundle between the board-pin side and the game core.
// The slave modport is the conditioner; the master modport is whoever drives the pins.
interface btn_if #(
  parameter int N_BTN = 4
) ();
  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;
  logic [IDX_W-1:0] last_idx;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, any_press, last_idx
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, any_press, last_idx
  );
endinterface

// File: rtl/btn_conditioner.sv
// N-channel pushbutton conditioner: synchroniser, debouncer, press/release pulses, last-pressed index.
// Define BTN_REPEAT_EN to add per-channel auto-repeat press pulses while a button is held.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input logic  clk,
  input logic  rst,
  btn_if.slave bus
);
  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] norm;
  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] press_pend;
  logic [N_BTN-1:0] rel_pend;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [N_BTN-1:0] press_d;
  logic [IDX_W-1:0] idx_d;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] rel_q;
  logic [IDX_W-1:0] idx_q;

  assign norm = (ACTIVE_LOW != 0) ? ~bus.btn_raw : bus.btn_raw;
  assign s    = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= norm;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Any bounce back to the stable value throws away the partial count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable     <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        press_pend[i] <= 1'b0;
        rel_pend[i]   <= 1'b0;
        if (s[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TERM) begin
          stable[i]     <= s[i];
          db_cnt[i]     <= '0;
          press_pend[i] <= s[i];
          rel_pend[i]   <= ~s[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_TERM  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_TERM = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_PERIOD} rep_state_t;

  rep_state_t       rep_state   [N_BTN];
  rep_state_t       rep_state_d [N_BTN];
  logic [REP_W-1:0] rep_cnt     [N_BTN];
  logic [REP_W-1:0] rep_cnt_d   [N_BTN];
  logic [N_BTN-1:0] rep_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_state[i] <= REP_IDLE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_state[i] <= rep_state_d[i];
        rep_cnt[i]   <= rep_cnt_d[i];
      end
    end
  end

  // The counter runs aligned with the output stage; a release arriving on a repeat slot wins.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rep_state_d[i] = rep_state[i];
      rep_cnt_d[i]   = rep_cnt[i];
      rep_fire[i]    = 1'b0;
      case (rep_state[i])
        REP_IDLE: begin
          if (press_pend[i]) begin
            rep_state_d[i] = REP_DELAY;
            rep_cnt_d[i]   = '0;
          end
        end
        REP_DELAY, REP_PERIOD: begin
          if (rel_pend[i]) begin
            rep_state_d[i] = REP_IDLE;
            rep_cnt_d[i]   = '0;
          end else if (rep_cnt[i] == ((rep_state[i] == REP_DELAY) ? DELAY_TERM : PERIOD_TERM)) begin
            rep_fire[i]    = 1'b1;
            rep_state_d[i] = REP_PERIOD;
            rep_cnt_d[i]   = '0;
          end else begin
            rep_cnt_d[i] = rep_cnt[i] + REP_W'(1);
          end
        end
        default: begin
          rep_state_d[i] = REP_IDLE;
          rep_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign press_d = press_pend | rep_fire;
`else
  assign press_d = press_pend;
`endif

  // Scan downward so the lowest pulsing channel is the one that sticks.
  always_comb begin
    idx_d = idx_q;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_d[i]) idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      idx_q   <= '0;
    end else begin
      level_q <= stable;
      press_q <= press_d;
      rel_q   <= rel_pend;
      idx_q   <= idx_d;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;
  assign bus.any_press   = |press_q;
  assign bus.last_idx    = idx_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat constants.
// Expectations for auto-repeat follow whether BTN_REPEAT_EN is defined for the build.
module tb_btn_conditioner;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  btn_if #(.N_BTN(4)) bus ();

  btn_conditioner #(
    .N_BTN(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(0),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic [1:0] idx);
    check_output({tag, "_level"},   32'(bus.btn_level),   32'(lvl));
    check_output({tag, "_press"},   32'(bus.btn_press),   32'(prs));
    check_output({tag, "_release"}, 32'(bus.btn_release), 32'(rel));
    check_output({tag, "_any"},     32'(bus.any_press),   32'(|prs));
    check_output({tag, "_idx"},     32'(bus.last_idx),    32'(idx));
  endtask

  // Holds reset for two edges, then releases it; the next edge is cycle 0.
  task automatic apply_stimulus(input string tag, input logic [3:0] raw_during, input logic [3:0] raw_after);
    bus.btn_raw = raw_during;
    rst = 1'b0;
    #1;
    check_all({tag, "_in_reset"}, 4'h0, 4'h0, 4'h0, 2'd0);
    tick();
    tick();
    check_all({tag, "_in_reset_clk"}, 4'h0, 4'h0, 4'h0, 2'd0);
    bus.btn_raw = raw_after;
    rst = 1'b1;
    cyc = -1;
  endtask

  initial begin
    logic [3:0] exp_p;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b0;
    bus.btn_raw = 4'h0;
    #2;

    // 1: all pressed through reset, then all released
    apply_stimulus("t1", 4'hF, 4'hF);
    for (int c = 0; c <= 7; c++) begin
      tick();
      check_all("t1", (cyc >= 6) ? 4'hF : 4'h0, (cyc == 6) ? 4'hF : 4'h0, 4'h0, 2'd0);
    end
    bus.btn_raw = 4'h0;
    for (int c = 8; c <= 15; c++) begin
      tick();
      check_output("t1_rel_pulse", 32'(bus.btn_release), (cyc == 14) ? 32'hF : 32'h0);
      check_output("t1_rel_level", 32'(bus.btn_level), (cyc >= 14) ? 32'h0 : 32'hF);
    end

    // 2: single press on channel 0
    apply_stimulus("t2", 4'h0, 4'h1);
    for (int c = 0; c <= 7; c++) begin
      tick();
      check_all("t2", (cyc >= 6) ? 4'h1 : 4'h0, (cyc == 6) ? 4'h1 : 4'h0, 4'h0, 2'd0);
    end

    // 3: channel 1 bounces every 2 cycles, never accepted
    for (int c = 0; c < 28; c++) begin
      bus.btn_raw[1] = (c < 20) ? ~c[1] : 1'b0;
      tick();
      check_output("t3_level1", 32'(bus.btn_level[1]), 32'h0);
      check_output("t3_press1", 32'(bus.btn_press[1]), 32'h0);
      check_output("t3_rel1",   32'(bus.btn_release[1]), 32'h0);
    end

    // 4: simultaneous press on 1 and 3, then release of 3
    apply_stimulus("t4", 4'h0, 4'h0);
    tick(); tick(); tick();
    bus.btn_raw = 4'hA;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (cyc >= 8) check_all("t4_press", (cyc >= 9) ? 4'hA : 4'h0,
                              (cyc == 9) ? 4'hA : 4'h0, 4'h0, (cyc >= 9) ? 2'd1 : 2'd0);
    end
    tick(); tick();
    bus.btn_raw = 4'h2;
`ifdef BTN_REPEAT_EN
    exp_p = 4'h2;
`else
    exp_p = 4'h0;
`endif
    for (int c = 13; c <= 20; c++) begin
      tick();
      if (cyc >= 18) check_all("t4_release", (cyc >= 19) ? 4'h2 : 4'hA,
                               (cyc == 19) ? exp_p : 4'h0,
                               (cyc == 19) ? 4'h8 : 4'h0, 2'd1);
    end

    // 5: reset lands mid-debounce on channel 2
    apply_stimulus("t5", 4'h0, 4'h4);
    for (int c = 0; c <= 2; c++) begin
      tick();
      check_output("t5_pre_press", 32'(bus.btn_press), 32'h0);
    end
    apply_stimulus("t5_mid", 4'h4, 4'h4);
    for (int c = 0; c <= 7; c++) begin
      tick();
      check_all("t5_after", (cyc >= 6) ? 4'h4 : 4'h0, (cyc == 6) ? 4'h4 : 4'h0, 4'h0, (cyc >= 6) ? 2'd2 : 2'd0);
    end

    // 6: long hold on channel 0 (auto-repeat when enabled)
    apply_stimulus("t6", 4'h0, 4'h1);
    for (int c = 0; c <= 50; c++) begin
      tick();
`ifdef BTN_REPEAT_EN
      exp_p = (cyc == 6 || cyc == 16 || cyc == 21 || cyc == 26 ||
               cyc == 31 || cyc == 36 || cyc == 41) ? 4'h1 : 4'h0;
`else
      exp_p = (cyc == 6) ? 4'h1 : 4'h0;
`endif
      check_output("t6_press",   32'(bus.btn_press),   32'(exp_p));
      check_output("t6_release", 32'(bus.btn_release), (cyc == 46) ? 32'h1 : 32'h0);
      check_output("t6_level",   32'(bus.btn_level),   (cyc >= 6 && cyc <= 45) ? 32'h1 : 32'h0);
      if (cyc == 39) bus.btn_raw = 4'h0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised N-channel input conditioner for the game's pushbuttons (up/down/left/right today, more later). Each raw pin is synchronised into the pixel-clock domain, debounced, and turned into a clean level plus single-cycle press and release pulses. A priority encoder reports the most recently pressed channel. The block sits between the board pins and the game core, so the core never sees raw, bouncing inputs.

Parameters:
N_BTN, 4, number of button channels (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
DEBOUNCE_CYCLES, 250000, stable cycles required to accept a change (10 ms at 25 MHz; >=2)
ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed (inverted at input)
REPEAT_DELAY, 12500000, cycles from accepted press to first auto-repeat pulse (BTN_REPEAT_EN only)
REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (BTN_REPEAT_EN only)

Ports:
clk  input  1  pixel clock (25 MHz); all logic on rising edge
rst  input  1  asynchronous, active-low reset; 0 = reset asserted
btn_raw  input  N_BTN  raw button pins, asynchronous to clk
btn_level  output  N_BTN  debounced level, 1 = pressed
btn_press  output  N_BTN  one-cycle pulse on accepted press (and on auto-repeat)
btn_release  output  N_BTN  one-cycle pulse on accepted release
any_press  output  1  OR of btn_press
last_idx  output  $clog2(N_BTN) (min 1)  index of the last pressed channel

Behaviour:
- Reset (rst=0, asynchronous): every synchroniser stage, stable level, counter, pulse, last_idx and repeat state cleared to 0. All outputs are 0 during reset and in the first cycle after it.
- Normalisation: n[i] = btn_raw[i] ^ ACTIVE_LOW. The result feeds a SYNC_STAGES-deep chain. s[i] is the last stage.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES):
  - s == stable: counter <= 0.
  - s != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != stable and counter == DEBOUNCE_CYCLES-1: stable <= s, counter <= 0, and a pulse is raised in the same registered update. The pulse is btn_press if s=1, btn_release if s=0.
  - Any return of s to stable before the terminal count restarts the count from 0. No partial credit is kept.
- Latency: a raw change that holds still appears on btn_level exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk edge that samples it. btn_press/btn_release are asserted in the same cycle btn_level changes and last exactly 1 cycle.
- Outputs: btn_level = stable, registered. btn_press/btn_release are registered. any_press is combinational OR of btn_press.
- last_idx: updates in the cycle any_press=1 to the lowest-numbered channel pulsing that cycle, and holds otherwise. Simultaneous presses resolve to the lowest index.
- Channels are fully independent. There is no cross-channel suppression.
- Reset mid-count: any count in progress is discarded and no pulse is emitted.

Optional Feature:
- Macro BTN_REPEAT_EN.
- Defined:
  - Each channel gets a repeat counter that clears on its accepted press.
  - While btn_level[i]=1, an extra btn_press[i] pulse is emitted REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - A repeat pulse also updates last_idx and any_press.
  - A repeat pulse that would fall in the cycle btn_release[i] fires is suppressed, and the counter stops.
  - Counter width is $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD).
- Undefined: the repeat logic is absent, each accepted press yields exactly one btn_press pulse, and the REPEAT_* parameters are ignored.

Test Plan:
Bench parameters: N_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, REPEAT_DELAY=10, REPEAT_PERIOD=5. Cycle 0 is the first edge after rst goes high.
1. btn_raw=4'b1111 held through reset -> all outputs 0 while rst=0; btn_level=1111 and btn_press=1111 for one cycle at cycle 6; last_idx=0.
2. btn_raw[0] 0->1 at cycle 0, held -> btn_level[0] rises at cycle 6; btn_press[0]=1 at cycle 6 only; any_press=1 at cycle 6; last_idx=0.
3. btn_raw[1] toggled every 2 cycles for 20 cycles, then held 0 -> btn_level[1] stays 0; no btn_press or btn_release pulses.
4. btn_raw[1] and btn_raw[3] rise in the same cycle -> btn_press=4'b1010 in one cycle; last_idx=1. Then btn_raw[3] falls -> btn_release[3] pulses 6 cycles later; last_idx stays 1.
5. btn_raw[2] high for 3 cycles, then rst pulsed low for 1 cycle while raw stays high -> no pulse before reset; outputs 0 during reset; btn_press[2] fires 6 cycles after rst returns high.
6. BTN_REPEAT_EN defined, btn_raw[0] high cycles 0-39, then low:
   - btn_press[0] at cycles 6, 16, 21, 26, 31, 36, 41;
   - btn_release[0] at cycle 46, with no btn_press that cycle.
   - Macro undefined, same stimulus: btn_press[0] only at cycle 6.
